// File: rtl/if_stage_pkg.sv
// Shared widths and default constants for the instruction-fetch stage.
// Imported by if_stage and pc_incr so address/instruction widths agree.
package if_stage_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0]  PC_STEP           = 32'd4;
   localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC  = 32'h0000_0000;

   // Instruction addresses are word aligned; the low two bits never reach the PC.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & ~(ADDR_W'(3));
   endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential-fetch address adder: next = pc + PC_STEP, wrapping modulo 2^ADDR_W.
module pc_incr
   import if_stage_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4
);

   assign pc_plus4 = pc + PC_STEP;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Per-edge priority is rst > redirect_valid > flush > stall > normal advance.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_addr,
   input  logic [INSTR_W-1:0]  imem_instr,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [ADDR_W-1:0]   if_id_pc4,
   output logic                if_id_valid,
   output logic [31:0]         fetch_count
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;

   pc_incr u_pc_incr (
      .pc       (pc),
      .pc_plus4 (pc_plus4)
   );

   assign imem_addr = pc;

   // if_id_valid qualifies the IF/ID contents: decode consumes if_id_instr/pc4
   // only while it is 1; a bubble (valid=0) always carries NOP_INSTR and pc4=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= word_align(RESET_PC);
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc          <= word_align(redirect_addr);
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (flush) begin
         // The wrong-path word is dropped, but fetch still moves on unless held.
         if (!stall) begin
            pc <= pc_plus4;
         end
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         pc          <= pc_plus4;
         if_id_instr <= imem_instr;
         if_id_pc4   <= pc_plus4;
         if_id_valid <= 1'b1;
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage driving a modelled combinational memory
// where the word at address A is 0x1000 + A/4.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic [31:0] imem_instr;
   logic [31:0] imem_addr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   int          n_checks = 0;
   int          n_fails  = 0;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_instr     (imem_instr),
      .imem_addr      (imem_addr),
      .if_id_instr    (if_id_instr),
      .if_id_pc4      (if_id_pc4),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic logic [31:0] im_word(input logic [31:0] addr);
      return 32'h1000 + {2'b00, addr[31:2]};
   endfunction

   assign imem_instr = im_word(imem_addr);

   initial begin
      #500000;
      $display("FAIL watchdog sim time limit expired");
      $fatal(1, "watchdog");
   end

   // driver tasks: inputs change 1ns after the edge, outputs sampled there too
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r, input logic s, input logic f,
                         input logic rv, input logic [31:0] ra);
      rst = r; stall = s; flush = f; redirect_valid = rv; redirect_addr = ra;
   endtask

   task automatic do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Normal-advance cycle: scoreboard expects the word at the current PC.
   task automatic free_cycle();
      exp_q.push_back(im_word(imem_addr));
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
   endtask

   task automatic test_reset();
      set_in(1'b1, 1'b1, 1'b1, 1'b1, $urandom_range(32'h100, 32'hFFFF));
      step();
      n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fails++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 32'h0); end
      n_checks++; if (if_id_pc4 !== 32'h0) begin n_fails++; $display("FAIL reset_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
      n_checks++; if (fetch_count !== 32'h0) begin n_fails++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_free_run();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (imem_addr !== 32'(i * 4)) begin n_fails++; $display("FAIL free_addr%0d got=%h exp=%h", i, imem_addr, 32'(i * 4)); end
         free_cycle();
         exp_v = exp_q.pop_front();
         n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL free_instr%0d got=%h exp=%h", i, if_id_instr, exp_v); end
         n_checks++; if (if_id_pc4 !== 32'(i * 4 + 4)) begin n_fails++; $display("FAIL free_pc4%0d got=%h exp=%h", i, if_id_pc4, 32'(i * 4 + 4)); end
         n_checks++; if (if_id_valid !== 1'b1) begin n_fails++; $display("FAIL free_valid%0d got=%b exp=1", i, if_id_valid); end
      end
      n_checks++; if (fetch_count !== 32'd4) begin n_fails++; $display("FAIL free_count got=%0d exp=4", fetch_count); end
   endtask

   task automatic test_stall();
      do_reset();
      free_cycle(); void'(exp_q.pop_front());
      free_cycle(); void'(exp_q.pop_front());
      n_checks++; if (imem_addr !== 32'h8) begin n_fails++; $display("FAIL stall_start got=%h exp=%h", imem_addr, 32'h8); end
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         step();
         n_checks++; if (imem_addr !== 32'h8) begin n_fails++; $display("FAIL stall_pc%0d got=%h exp=%h", i, imem_addr, 32'h8); end
         n_checks++; if (if_id_instr !== 32'h1001) begin n_fails++; $display("FAIL stall_instr%0d got=%h exp=%h", i, if_id_instr, 32'h1001); end
         n_checks++; if (fetch_count !== 32'd2) begin n_fails++; $display("FAIL stall_count%0d got=%0d exp=2", i, fetch_count); end
      end
      free_cycle();
      exp_v = exp_q.pop_front();
      n_checks++; if (imem_addr !== 32'hC) begin n_fails++; $display("FAIL stall_release_pc got=%h exp=%h", imem_addr, 32'hC); end
      n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL stall_release_instr got=%h exp=%h", if_id_instr, exp_v); end
      n_checks++; if (fetch_count !== 32'd3) begin n_fails++; $display("FAIL stall_release_count got=%0d exp=3", fetch_count); end
   endtask

   task automatic test_redirect();
      // continues from pc=0xC, fetch_count=3
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0043);
      step();
      n_checks++; if (imem_addr !== 32'h40) begin n_fails++; $display("FAIL redir_pc got=%h exp=%h", imem_addr, 32'h40); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fails++; $display("FAIL redir_valid got=%b exp=0", if_id_valid); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fails++; $display("FAIL redir_instr got=%h exp=%h", if_id_instr, 32'h0); end
      n_checks++; if (if_id_pc4 !== 32'h0) begin n_fails++; $display("FAIL redir_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
      n_checks++; if (fetch_count !== 32'd3) begin n_fails++; $display("FAIL redir_count got=%0d exp=3", fetch_count); end
      free_cycle();
      exp_v = exp_q.pop_front();
      n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL redir_target_instr got=%h exp=%h", if_id_instr, exp_v); end
      n_checks++; if (if_id_instr !== 32'h1010) begin n_fails++; $display("FAIL redir_target_word got=%h exp=%h", if_id_instr, 32'h1010); end
      n_checks++; if (if_id_pc4 !== 32'h44) begin n_fails++; $display("FAIL redir_target_pc4 got=%h exp=%h", if_id_pc4, 32'h44); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         free_cycle(); void'(exp_q.pop_front());
      end
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      n_checks++; if (imem_addr !== 32'h14) begin n_fails++; $display("FAIL flush_pc got=%h exp=%h", imem_addr, 32'h14); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fails++; $display("FAIL flush_valid got=%b exp=0", if_id_valid); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fails++; $display("FAIL flush_instr got=%h exp=%h", if_id_instr, 32'h0); end
      n_checks++; if (fetch_count !== 32'd4) begin n_fails++; $display("FAIL flush_count got=%0d exp=4", fetch_count); end
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      n_checks++; if (imem_addr !== 32'h14) begin n_fails++; $display("FAIL flush_stall_pc got=%h exp=%h", imem_addr, 32'h14); end
      free_cycle();
      exp_v = exp_q.pop_front();
      n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL flush_resume_instr got=%h exp=%h", if_id_instr, exp_v); end
      n_checks++; if (fetch_count !== 32'd5) begin n_fails++; $display("FAIL flush_resume_count got=%0d exp=5", fetch_count); end
   endtask

   task automatic test_wrap();
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      step();
      n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL wrap_redir_pc got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
      free_cycle();
      exp_v = exp_q.pop_front();
      n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL wrap_instr got=%h exp=%h", if_id_instr, exp_v); end
      n_checks++; if (if_id_pc4 !== 32'h0) begin n_fails++; $display("FAIL wrap_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL wrap_pc got=%h exp=%h", imem_addr, 32'h0); end
      free_cycle();
      exp_v = exp_q.pop_front();
      n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL wrap_next_instr got=%h exp=%h", if_id_instr, exp_v); end
      n_checks++; if (if_id_pc4 !== 32'h4) begin n_fails++; $display("FAIL wrap_next_pc4 got=%h exp=%h", if_id_pc4, 32'h4); end
   endtask

   task automatic test_reset_midstream();
      free_cycle(); void'(exp_q.pop_front());
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
      step();
      n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL mid_rst_pc got=%h exp=%h", imem_addr, 32'h0); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fails++; $display("FAIL mid_rst_valid got=%b exp=0", if_id_valid); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fails++; $display("FAIL mid_rst_instr got=%h exp=%h", if_id_instr, 32'h0); end
      n_checks++; if (if_id_pc4 !== 32'h0) begin n_fails++; $display("FAIL mid_rst_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
      n_checks++; if (fetch_count !== 32'h0) begin n_fails++; $display("FAIL mid_rst_count got=%0d exp=0", fetch_count); end
      free_cycle();
      exp_v = exp_q.pop_front();
      n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL mid_first_instr got=%h exp=%h", if_id_instr, exp_v); end
      n_checks++; if (if_id_instr !== 32'h1000) begin n_fails++; $display("FAIL mid_first_word got=%h exp=%h", if_id_instr, 32'h1000); end
      n_checks++; if (fetch_count !== 32'd1) begin n_fails++; $display("FAIL mid_first_count got=%0d exp=1", fetch_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] m_pc;
      logic [31:0] m_cnt;
      logic [31:0] m_instr;
      logic        m_valid;
      logic        s, f, adv;
      do_reset();
      m_pc = 32'h0; m_cnt = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 4) == 0);
         adv = !s && !f;
         if (adv) begin
            exp_q.push_back(im_word(m_pc));
            m_instr = im_word(m_pc); m_valid = 1'b1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
         end else if (f) begin
            m_instr = 32'h0; m_valid = 1'b0;
            if (!s) m_pc = m_pc + 4;
         end
         set_in(1'b0, s, f, 1'b0, 32'h0);
         step();
         n_checks++; if (imem_addr !== m_pc) begin n_fails++; $display("FAIL b2b_pc%0d got=%h exp=%h", i, imem_addr, m_pc); end
         n_checks++; if (fetch_count !== m_cnt) begin n_fails++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, fetch_count, m_cnt); end
         n_checks++; if (if_id_valid !== m_valid) begin n_fails++; $display("FAIL b2b_valid%0d got=%b exp=%b", i, if_id_valid, m_valid); end
         if (adv) begin
            exp_v = exp_q.pop_front();
            n_checks++; if (if_id_instr !== exp_v) begin n_fails++; $display("FAIL b2b_instr%0d got=%h exp=%h", i, if_id_instr, exp_v); end
         end else begin
            n_checks++; if (if_id_instr !== m_instr) begin n_fails++; $display("FAIL b2b_hold%0d got=%h exp=%h", i, if_id_instr, m_instr); end
         end
      end
   endtask

   initial begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_flush();
      test_wrap();
      test_reset_midstream();
      test_back_to_back();
      n_checks++; if (exp_q.size() != 0) begin n_fails++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
